// File: rtl/param_user_register_pkg.sv
// Shared definitions for the CPU register slice.
//   CPU_WIDTH  : default datapath width of the user registers
//   MODE_WRAP  : inc/dec wraps modulo 2^WIDTH
//   MODE_SAT   : inc/dec clamps at 2^WIDTH-1 and at 0
//   clog2()    : ceiling log2, used to size the stack count port
package cpu_reg_pkg;

  localparam int unsigned CPU_WIDTH = 19;
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_user_register_if.sv
// Request/status bundle of the user register.
//   master : writeback side driving inpData/STEP/LOAD/INC/DEC/CLR/PUSH/POP
//   slave  : the register, returning opData/ZERO/OVF and stack status
interface param_user_register_if
  import cpu_reg_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] inpData;
  logic [WIDTH-1:0] STEP;
  logic             LOAD;
  logic             INC;
  logic             DEC;
  logic             CLR;
  logic             PUSH;
  logic             POP;
  logic [WIDTH-1:0] opData;
  logic             ZERO;
  logic             OVF;
  logic [CW-1:0]    STK_CNT;
  logic             STK_FULL;
  logic             STK_EMPTY;
  logic             STK_ERR;

  modport master (
    output inpData, STEP, LOAD, INC, DEC, CLR, PUSH, POP,
    input  opData, ZERO, OVF, STK_CNT, STK_FULL, STK_EMPTY, STK_ERR
  );

  modport slave (
    input  inpData, STEP, LOAD, INC, DEC, CLR, PUSH, POP,
    output opData, ZERO, OVF, STK_CNT, STK_FULL, STK_EMPTY, STK_ERR
  );

endinterface

// File: rtl/param_user_register_lifo.sv
// Save/restore stack for the user register (falling-edge clocked).
//   clk, rst_n : clock (state on negedge), async active-low reset
//   push, pop  : requests; both together with a non-empty stack exchange
//                din with the top entry, pointer unchanged
//   din        : value to save (register value before this edge)
//   top        : current top entry (valid when not empty)
//   cnt/full/empty : occupancy derived from the pointer
//   err        : registered one-cycle pulse when a request is dropped
module reg_lifo
  import cpu_reg_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [CW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic             xchg;
  logic             err_d;

  assign empty   = (ptr == '0);
  assign full    = (ptr == CW'(DEPTH));
  assign cnt     = ptr;
  assign xchg    = push & pop & ~empty;
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign err_d   = (push & pop & empty) | (push & ~pop & full) | (pop & ~push & empty);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      err <= 1'b0;
    end else begin
      err <= err_d;
      if (do_push)
        ptr <= ptr + 1'b1;
      else if (do_pop)
        ptr <= ptr - 1'b1;
    end
  end

  // Storage is not reset; a push writes slot ptr, an exchange overwrites slot ptr-1.
  always_ff @(negedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((do_push && ptr == CW'(i)) || (xchg && ptr == CW'(i + 1)))
        mem[i] <= din;
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ptr == CW'(i + 1))
        top = mem[i];
    end
  end

endmodule

// File: rtl/param_user_register.sv
// Parametrised general-purpose/pointer register with step inc/dec,
// wrap or saturate arithmetic, overflow/zero status and a save stack.
//   CLK   : clock, all state changes on the falling edge
//   RST_N : asynchronous active-low reset
//   bus   : slave side of param_user_register_if (controls in, status out)
// Value priority per edge: CLR > POP (non-empty) > LOAD > INC > DEC > hold.
module param_user_register
  import cpu_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = CPU_WIDTH,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
  input  logic                 CLK,
  input  logic                 RST_N,
  param_user_register_if.slave bus
);

  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] top;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             pop_req;
  logic             pop_ok;
  logic             stk_empty;

  // CLR masks POP so the stack stays untouched; PUSH is never masked.
  assign pop_req = bus.POP & ~bus.CLR;
  assign pop_ok  = pop_req & ~stk_empty;

  assign sum  = {1'b0, op_q} + {1'b0, bus.STEP};
  assign diff = {1'b0, op_q} - {1'b0, bus.STEP};

  always_comb begin
    op_d  = op_q;
    ovf_d = 1'b0;
    if (bus.CLR) begin
      op_d = RESET_VAL;
    end else if (pop_ok) begin
      op_d = top;
    end else if (bus.LOAD) begin
      op_d = bus.inpData;
    end else if (bus.INC) begin
      ovf_d = sum[WIDTH];
      if (sum[WIDTH] && SATURATE == MODE_SAT)
        op_d = '1;
      else
        op_d = sum[WIDTH-1:0];
    end else if (bus.DEC) begin
      ovf_d = diff[WIDTH];
      if (diff[WIDTH] && SATURATE == MODE_SAT)
        op_d = '0;
      else
        op_d = diff[WIDTH-1:0];
    end
  end

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q  <= RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      ovf_q <= ovf_d;
    end
  end

  reg_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (bus.PUSH),
    .pop   (pop_req),
    .din   (op_q),
    .top   (top),
    .cnt   (bus.STK_CNT),
    .full  (bus.STK_FULL),
    .empty (stk_empty),
    .err   (bus.STK_ERR)
  );

  assign bus.opData    = op_q;
  assign bus.ZERO      = (op_q == '0);
  assign bus.OVF       = ovf_q;
  assign bus.STK_EMPTY = stk_empty;

endmodule

// File: tb/tb_param_user_register.sv
// Bench for param_user_register: a wrap-mode and a saturate-mode instance
// receive identical stimulus and are compared against a queue-based model;
// a directed vector table and hand sequences pin down the corner cases.
module tb_param_user_register;
  import cpu_reg_pkg::*;

  localparam int unsigned W     = 19;
  localparam int unsigned DEP   = 4;
  localparam int unsigned MAXV  = (1 << W) - 1;

  localparam logic [5:0] L = 6'b100000;
  localparam logic [5:0] I = 6'b010000;
  localparam logic [5:0] D = 6'b001000;
  localparam logic [5:0] C = 6'b000100;
  localparam logic [5:0] P = 6'b000010;
  localparam logic [5:0] Q = 6'b000001;
  localparam logic [5:0] N = 6'b000000;

  logic clk;
  logic rst_n;

  param_user_register_if #(.WIDTH(W), .DEPTH(DEP)) bw ();
  param_user_register_if #(.WIDTH(W), .DEPTH(DEP)) bs ();

  param_user_register #(.WIDTH(W), .DEPTH(DEP), .SATURATE(MODE_WRAP), .RESET_VAL('0)) dut_w (
    .CLK(clk), .RST_N(rst_n), .bus(bw));
  param_user_register #(.WIDTH(W), .DEPTH(DEP), .SATURATE(MODE_SAT), .RESET_VAL('0)) dut_s (
    .CLK(clk), .RST_N(rst_n), .bus(bs));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int fails  = 0;

  // Reference model state: index 0 = wrap instance, 1 = saturate instance.
  int unsigned mval [2];
  int unsigned mq   [2][$];
  bit          movf [2];
  bit          merr [2];

  logic [5:0]   cur_c;
  logic [W-1:0] cur_d;
  logic [W-1:0] cur_s;

  typedef struct {
    logic [5:0]   c;
    logic [W-1:0] din;
    logic [W-1:0] step;
    logic [W-1:0] eop;
    logic         eovf;
    int unsigned  ecnt;
    logic         eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] c, input int unsigned din, input int unsigned step,
                              input int unsigned eop, input bit eovf, input int unsigned ecnt,
                              input bit eerr);
    vec_t v;
    v.c = c; v.din = W'(din); v.step = W'(step); v.eop = W'(eop);
    v.eovf = eovf; v.ecnt = ecnt; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mval[m] = 0;
      mq[m].delete();
      movf[m] = 0;
      merr[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int unsigned old;
    int unsigned topv;
    bit popok;
    bit sat;
    bit ld, inc, dec, clr, push, pope;
    longint s;
    sat = (m == 1);
    ld = cur_c[5]; inc = cur_c[4]; dec = cur_c[3]; clr = cur_c[2]; push = cur_c[1];
    pope = cur_c[0] && !clr;
    old = mval[m];
    topv = 0;
    popok = 0;
    movf[m] = 0;
    merr[m] = 0;
    if (push && pope) begin
      if (mq[m].size() == 0) merr[m] = 1;
      else begin
        topv = mq[m][$];
        mq[m][mq[m].size() - 1] = old;
        popok = 1;
      end
    end else if (push) begin
      if (mq[m].size() == DEP) merr[m] = 1;
      else mq[m].push_back(old);
    end else if (pope) begin
      if (mq[m].size() == 0) merr[m] = 1;
      else begin
        topv = mq[m].pop_back();
        popok = 1;
      end
    end
    if (clr) mval[m] = 0;
    else if (popok) mval[m] = topv;
    else if (ld) mval[m] = int'(cur_d);
    else if (inc) begin
      s = longint'(old) + longint'(cur_s);
      if (s > longint'(MAXV)) begin
        movf[m] = 1;
        mval[m] = sat ? MAXV : int'(s - longint'(MAXV) - 1);
      end else mval[m] = int'(s);
    end else if (dec) begin
      if (int'(cur_s) > old) begin
        movf[m] = 1;
        mval[m] = sat ? 0 : int'(longint'(old) + longint'(MAXV) + 1 - longint'(cur_s));
      end else mval[m] = old - int'(cur_s);
    end
  endtask

  task automatic compare(input int m);
    logic [W-1:0] op;
    logic z, o, f, e, er;
    logic [2:0] cnt;
    string t;
    if (m == 0) begin
      op = bw.opData; z = bw.ZERO; o = bw.OVF; f = bw.STK_FULL; e = bw.STK_EMPTY;
      er = bw.STK_ERR; cnt = bw.STK_CNT; t = "wrap";
    end else begin
      op = bs.opData; z = bs.ZERO; o = bs.OVF; f = bs.STK_FULL; e = bs.STK_EMPTY;
      er = bs.STK_ERR; cnt = bs.STK_CNT; t = "sat";
    end
    chk({t, " opData"},    32'(op),  mval[m]);
    chk({t, " ZERO"},      32'(z),   32'(mval[m] == 0));
    chk({t, " OVF"},       32'(o),   32'(movf[m]));
    chk({t, " STK_CNT"},   32'(cnt), mq[m].size());
    chk({t, " STK_FULL"},  32'(f),   32'(mq[m].size() == DEP));
    chk({t, " STK_EMPTY"}, 32'(e),   32'(mq[m].size() == 0));
    chk({t, " STK_ERR"},   32'(er),  32'(merr[m]));
  endtask

  task automatic drive(input logic [5:0] c, input logic [W-1:0] d, input logic [W-1:0] s);
    cur_c = c; cur_d = d; cur_s = s;
    bw.LOAD = c[5]; bw.INC = c[4]; bw.DEC = c[3]; bw.CLR = c[2]; bw.PUSH = c[1]; bw.POP = c[0];
    bs.LOAD = c[5]; bs.INC = c[4]; bs.DEC = c[3]; bs.CLR = c[2]; bs.PUSH = c[1]; bs.POP = c[0];
    bw.inpData = d; bw.STEP = s;
    bs.inpData = d; bs.STEP = s;
  endtask

  // Apply one request across a falling edge, then check both instances.
  task automatic cycle(input logic [5:0] c, input logic [W-1:0] d, input logic [W-1:0] s);
    drive(c, d, s);
    @(negedge clk);
    #1;
    model_step(0);
    model_step(1);
    compare(0);
    compare(1);
  endtask

  // Assert reset between edges and check its effect without waiting for a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare(0);
    compare(1);
    chk("async opData", 32'(bw.opData), 32'h0);
    chk("async STK_EMPTY", 32'(bw.STK_EMPTY), 32'h1);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] c;
    logic [W-1:0] d, s;

    rst_n = 1'b0;
    drive(N, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare(0);
    compare(1);
    @(posedge clk);
    rst_n = 1'b1;

    cycle(L, W'('h3AB), '0);
    do_reset();

    tbl.push_back(mk(L|I, 'h1234, 1, 'h1234, 0, 0, 0));
    tbl.push_back(mk(C|L, 'h5555, 0, 0, 0, 0, 0));
    tbl.push_back(mk(L, 'h7FFFE, 0, 'h7FFFE, 0, 0, 0));
    tbl.push_back(mk(I, 0, 3, 'h00001, 1, 0, 0));
    tbl.push_back(mk(N, 0, 3, 'h00001, 0, 0, 0));
    tbl.push_back(mk(D, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(L, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(P|L, 2, 0, 2, 0, 1, 0));
    tbl.push_back(mk(P|L, 3, 0, 3, 0, 2, 0));
    tbl.push_back(mk(P|L, 4, 0, 4, 0, 3, 0));
    tbl.push_back(mk(P, 0, 0, 4, 0, 4, 0));
    tbl.push_back(mk(P, 0, 0, 4, 0, 4, 1));
    tbl.push_back(mk(Q, 0, 0, 4, 0, 3, 0));
    tbl.push_back(mk(Q, 0, 0, 3, 0, 2, 0));
    tbl.push_back(mk(Q, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(Q, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(Q, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(Q|L, 'h77, 0, 'h77, 0, 0, 1));
    tbl.push_back(mk(L, 'h20, 0, 'h20, 0, 0, 0));
    tbl.push_back(mk(P|L, 'h10, 0, 'h10, 0, 1, 0));
    tbl.push_back(mk(P|Q, 0, 0, 'h20, 0, 1, 0));
    tbl.push_back(mk(Q, 0, 0, 'h10, 0, 0, 0));
    tbl.push_back(mk(L, 5, 0, 5, 0, 0, 0));
    tbl.push_back(mk(P|I, 0, 1, 6, 0, 1, 0));
    tbl.push_back(mk(Q, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(P|Q, 0, 0, 5, 0, 0, 1));
    tbl.push_back(mk(P, 0, 0, 5, 0, 1, 0));
    tbl.push_back(mk(C|Q, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(C|P|L, 9, 0, 0, 0, 2, 0));
    tbl.push_back(mk(Q, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(Q, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(I|D, 0, 2, 7, 0, 0, 0));
    tbl.push_back(mk(D, 0, 8, 'h7FFFF, 1, 0, 0));
    tbl.push_back(mk(I, 0, 0, 'h7FFFF, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      cycle(tbl[k].c, tbl[k].din, tbl[k].step);
      chk($sformatf("vec%0d opData", k), 32'(bw.opData), 32'(tbl[k].eop));
      chk($sformatf("vec%0d ZERO", k), 32'(bw.ZERO), 32'(tbl[k].eop == '0));
      chk($sformatf("vec%0d OVF", k), 32'(bw.OVF), 32'(tbl[k].eovf));
      chk($sformatf("vec%0d STK_CNT", k), 32'(bw.STK_CNT), tbl[k].ecnt);
      chk($sformatf("vec%0d STK_FULL", k), 32'(bw.STK_FULL), 32'(tbl[k].ecnt == DEP));
      chk($sformatf("vec%0d STK_ERR", k), 32'(bw.STK_ERR), 32'(tbl[k].eerr));
    end

    cycle(L, W'('h7FFFE), '0);
    cycle(I, '0, W'(3));
    chk("sat inc clamp", 32'(bs.opData), 32'h7FFFF);
    chk("sat inc OVF", 32'(bs.OVF), 32'h1);
    cycle(L, W'(2), '0);
    chk("sat OVF one cycle", 32'(bs.OVF), 32'h0);
    cycle(D, '0, W'(5));
    chk("sat dec clamp", 32'(bs.opData), 32'h0);
    chk("sat dec OVF", 32'(bs.OVF), 32'h1);
    chk("sat dec ZERO", 32'(bs.ZERO), 32'h1);

    cycle(P|L, W'('h11), '0);
    cycle(P|L, W'('h22), '0);
    cycle(P, '0, '0);
    chk("pre-reset STK_CNT", 32'(bw.STK_CNT), 32'h3);
    do_reset();
    chk("post-reset STK_CNT", 32'(bw.STK_CNT), 32'h0);
    cycle(Q, '0, '0);
    chk("pop after reset STK_ERR", 32'(bw.STK_ERR), 32'h1);
    chk("pop after reset opData", 32'(bw.opData), 32'h0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
      end else begin
        c[5] = ($urandom_range(3) == 0);
        c[4] = ($urandom_range(2) == 0);
        c[3] = ($urandom_range(2) == 0);
        c[2] = ($urandom_range(15) == 0);
        c[1] = ($urandom_range(2) == 0);
        c[0] = ($urandom_range(2) == 0);
        case ($urandom_range(3))
          0: d = W'($urandom);
          1: d = W'(MAXV - $urandom_range(3));
          2: d = W'($urandom_range(3));
          default: d = W'($urandom_range(255));
        endcase
        case ($urandom_range(4))
          0: s = '0;
          1: s = W'(1);
          2: s = W'($urandom_range(16));
          3: s = W'($urandom);
          default: s = '1;
        endcase
        cycle(c, d, s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/param_user_register.md
Name: param_user_register

Overview:
- Parametrised general-purpose/pointer register for the CPU datapath; successor to the fixed 19-bit load/inc/dec/clr register.
- Adds generic width, variable step size, and a wrap or saturate mode.
- Adds overflow and zero status, plus a DEPTH-entry save/restore LIFO (PUSH/POP) for context save of PC/SP-style registers.
- Sits between the ALU/bus writeback and the register read mux.

Parameters:
- WIDTH, 19, data width in bits (>=2).
- DEPTH, 4, save-stack entries (>=1).
- SATURATE, 0, 0 = inc/dec wraps modulo 2^WIDTH; 1 = clamps at 2^WIDTH-1 and at 0.
- RESET_VAL, 0, value of opData after reset or CLR.

Ports:
- CLK  in  1  clock; all state updates on the falling edge, as in the rest of the CPU.
- RST_N  in  1  asynchronous active-low reset.
- inpData  in  WIDTH  load value.
- STEP  in  WIDTH  inc/dec amount; 0 means hold.
- LOAD  in  1  load inpData.
- INC  in  1  add STEP.
- DEC  in  1  subtract STEP.
- CLR  in  1  synchronous clear to RESET_VAL.
- PUSH  in  1  save the current opData to the stack.
- POP  in  1  restore opData from the stack top.
- opData  out  WIDTH  register value.
- ZERO  out  1  combinational, opData == 0.
- OVF  out  1  registered one-cycle pulse: the last inc/dec crossed a boundary.
- STK_CNT  out  clog2(DEPTH+1)  entries held.
- STK_FULL  out  1  STK_CNT == DEPTH.
- STK_EMPTY  out  1  STK_CNT == 0.
- STK_ERR  out  1  registered one-cycle pulse: a stack operation was dropped.

Behaviour:
- Reset (RST_N low, any time, including mid-operation):
  - opData = RESET_VAL; stack pointer = 0; OVF = 0; STK_ERR = 0.
  - Stack contents are don't-care.
  - Release is taken at the next falling edge.
- Value update, per falling edge, priority order:
  - 1. CLR: opData <= RESET_VAL.
  - 2. POP, stack non-empty: opData <= top entry.
  - 3. LOAD: opData <= inpData.
  - 4. INC: opData <= opData + STEP.
  - 5. DEC: opData <= opData - STEP.
  - 6. Otherwise hold.
- INC and DEC both high: INC wins.
- A lower-priority request in the same cycle is discarded, with no side effects.
- Arithmetic is done in WIDTH+1 bits:
  - Wrap mode: the result is truncated to WIDTH bits.
  - Saturate mode: the result clamps to 2^WIDTH-1 on INC carry and to 0 on DEC borrow.
  - OVF <= 1 for the next cycle only when the inc/dec actually executed and had a carry/borrow, in either mode.
  - OVF <= 0 in all other cycles.
- Stack, evaluated independently of the value priority except for CLR:
  - PUSH alone, not full: entry[ptr] <= opData value before this edge's update; ptr+1. A PUSH coinciding with LOAD/INC/DEC therefore saves the old value.
  - PUSH alone, full: dropped; STK_ERR pulse.
  - POP alone, not empty: ptr-1; the value is restored per priority 2.
  - POP alone, empty: dropped; STK_ERR pulse; LOAD/INC/DEC below it proceed normally.
  - PUSH+POP, non-empty: exchange. opData <= top entry, top entry <= old opData, ptr unchanged. Works when full.
  - PUSH+POP, empty: both dropped; STK_ERR pulse.
  - CLR with POP: POP is ignored and the stack is unchanged.
  - CLR with PUSH: the push proceeds (saves the old value), then opData clears.
- STK_FULL, STK_EMPTY and STK_CNT are derived from ptr and update on the same edge as ptr.

Decomposition:
- Shared package cpu_reg_pkg:
  - CPU_WIDTH = 19 default.
  - Mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - Function clog2 for STK_CNT sizing.
- One sub-module, reg_lifo:
  - WIDTH x DEPTH storage, pointer, and full/empty/count.
  - push/pop/exchange inputs; top-of-stack output; err output.
- The top level holds the value priority logic, arithmetic and OVF.

Test Plan:
- Reset/priority: RST_N low asynchronously mid-cycle -> opData = 0, STK_EMPTY = 1 immediately. Then LOAD=1, INC=1, inpData=0x1234 -> opData = 0x1234. Then CLR=1 with LOAD=1 -> opData = 0.
- Wrap mode: opData=0x7FFFE, STEP=3, INC -> opData = 0x00001, OVF high exactly one cycle, ZERO = 0. Then DEC, STEP=1 -> 0, ZERO = 1, OVF = 0.
- SATURATE=1: opData=0x7FFFE, STEP=3, INC -> 0x7FFFF, OVF pulse. Then opData=2, STEP=5, DEC -> 0, OVF pulse.
- Stack fill/overflow (DEPTH=4): push 1, 2, 3, 4 -> STK_FULL = 1, STK_CNT = 4. A fifth PUSH -> STK_ERR pulse, STK_CNT stays 4. Four POPs -> opData = 4, 3, 2, 1, then STK_EMPTY = 1. A further POP -> STK_ERR, opData unchanged.
- Simultaneous ops:
  - opData=0x10, top=0x20, PUSH+POP -> opData = 0x20, top = 0x10, STK_CNT unchanged.
  - PUSH+INC, STEP=1, opData=5 -> stack top = 5, opData = 6.
  - CLR+POP -> opData = 0, STK_CNT unchanged.
- Reset mid-sequence: stack holding 3 entries, RST_N low -> STK_CNT = 0, opData = RESET_VAL. A following POP -> STK_ERR.
